// File: rtl/test_port_writer.sv
// Bus-master transmitter for the simulation test port: frames buffered producer words
// between begin/end symbols. Define TEST_PORT_WRITER_TIMEOUT_EN to add a stall timeout.
module test_port_writer #(
    parameter logic [29:0] TEST_PORT    = 30'h10,
    parameter logic [31:0] BEGIN_SYMBOL = 32'h00000168,
    parameter logic [31:0] END_SYMBOL   = 32'hFFFFFD5D,
    parameter int          NUM_WORDS    = 17,
    parameter int          FIFO_DEPTH   = 4
`ifdef TEST_PORT_WRITER_TIMEOUT_EN
    ,
    parameter int          STALL_LIMIT  = 64
`endif
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        in_valid,
    input  logic [31:0] in_data,
    output logic        in_ready,
    input  logic        stall,
    output logic [29:0] addr,
    output logic [31:0] data,
    output logic        wen,
    output logic        busy,
    output logic        done,
`ifdef TEST_PORT_WRITER_TIMEOUT_EN
    output logic        timeout,
`endif
    output logic [7:0]  sent_cnt
);
    localparam int          PW    = $clog2(FIFO_DEPTH);
    localparam logic [7:0]  NW    = 8'(NUM_WORDS);
    localparam logic [PW:0] DEPTH = (PW + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE, S_BEGIN, S_GAP, S_PAYLOAD, S_WAIT, S_END, S_DONE
    } state_t;

    state_t        state, state_nxt;
    logic [31:0]   mem [FIFO_DEPTH];
    logic [PW-1:0] wptr, rptr;
    logic [PW:0]   count;
    logic [7:0]    accepted_cnt, payload_cnt;
    logic          end_sent;
    logic [31:0]   cur_word, word;
    logic          full, empty, push, pop, clear, wr_done, tmo_hit;

    // Bus outputs decode straight from the state register so an async reset drops wen at once.
    assign wen      = (state == S_BEGIN) || (state == S_PAYLOAD) || (state == S_END);
    assign wr_done  = wen && !stall;
    assign busy     = (state != S_IDLE) && (state != S_DONE);
    assign done     = (state == S_DONE);
    assign full     = (count == DEPTH);
    assign empty    = (count == '0);
    assign in_ready = busy && !full && (accepted_cnt < NW);
    assign push     = in_valid && in_ready;

    always_comb begin
        word = cur_word;
        if (state == S_BEGIN) word = BEGIN_SYMBOL;
        if (state == S_END)   word = END_SYMBOL;
    end

    assign addr = wen ? TEST_PORT : '0;
    assign data = wen ? {word[7:0], word[15:8], word[23:16], word[31:24]} : '0;

`ifdef TEST_PORT_WRITER_TIMEOUT_EN
    localparam int SW = $clog2(STALL_LIMIT + 1);
    logic [SW-1:0] stall_cnt;

    assign tmo_hit = wen && stall && (stall_cnt == SW'(STALL_LIMIT - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= '0;
            timeout   <= 1'b0;
        end else begin
            stall_cnt <= (wen && stall && !tmo_hit) ? stall_cnt + 1'b1 : '0;
            if (clear)        timeout <= 1'b0;
            else if (tmo_hit) timeout <= 1'b1;
        end
    end
`else
    assign tmo_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        clear     = 1'b0;
        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_nxt = S_BEGIN;
                    clear     = 1'b1;
                end
            end
            S_BEGIN, S_PAYLOAD, S_END: begin
                if (wr_done) state_nxt = S_GAP;
            end
            S_GAP: begin
                if (payload_cnt < NW) begin
                    if (!empty) begin
                        state_nxt = S_PAYLOAD;
                        pop       = 1'b1;
                    end else begin
                        state_nxt = S_WAIT;
                    end
                end else if (!end_sent) begin
                    state_nxt = S_END;
                end else begin
                    state_nxt = S_DONE;
                end
            end
            S_WAIT: begin
                if (!empty) begin
                    state_nxt = S_PAYLOAD;
                    pop       = 1'b1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
        if (tmo_hit) state_nxt = S_DONE;
    end

    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= in_data;
    end

    // A new start flushes anything a timed-out sequence left behind in the buffer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr         <= '0;
            rptr         <= '0;
            count        <= '0;
            accepted_cnt <= '0;
            payload_cnt  <= '0;
            end_sent     <= 1'b0;
            sent_cnt     <= '0;
            cur_word     <= '0;
        end else if (clear) begin
            wptr         <= '0;
            rptr         <= '0;
            count        <= '0;
            accepted_cnt <= '0;
            payload_cnt  <= '0;
            end_sent     <= 1'b0;
            sent_cnt     <= '0;
        end else begin
            if (push) begin
                wptr         <= wptr + 1'b1;
                accepted_cnt <= accepted_cnt + 1'b1;
            end
            if (pop) begin
                rptr     <= rptr + 1'b1;
                cur_word <= mem[rptr];
            end
            count <= count + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
            if (wr_done) sent_cnt <= sent_cnt + 1'b1;
            if (wr_done && state == S_PAYLOAD) payload_cnt <= payload_cnt + 1'b1;
            if (wr_done && state == S_END)     end_sent    <= 1'b1;
        end
    end

endmodule

// File: tb/tb_test_port_writer.sv
// Self-checking bench for test_port_writer: table vectors, scripted corner cases and
// randomized sequences checked against a word-level model of the reporting protocol.
module tb_test_port_writer;
    localparam int N     = 17;
    localparam int DEPTH = 4;

    logic        clk, rst, start, in_valid, stall;
    logic [31:0] in_data, data;
    logic        in_ready, wen, busy, done;
    logic [29:0] addr;
    logic [7:0]  sent_cnt;
`ifdef TEST_PORT_WRITER_TIMEOUT_EN
    logic        timeout;
`endif

    test_port_writer #(
        .NUM_WORDS(N),
        .FIFO_DEPTH(DEPTH)
`ifdef TEST_PORT_WRITER_TIMEOUT_EN
        , .STALL_LIMIT(8)
`endif
    ) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .stall(stall), .addr(addr), .data(data), .wen(wen),
        .busy(busy), .done(done),
`ifdef TEST_PORT_WRITER_TIMEOUT_EN
        .timeout(timeout),
`endif
        .sent_cnt(sent_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] din;
        logic [31:0] dexp;
    } vec_t;
    vec_t tbl [N];

    int          checks = 0, errors = 0;
    logic [31:0] src [$];
    logic [31:0] obs [$];
    int          wlen [$];
    int          n_done, n_acc, tail, seq_cyc, done_at, run;
    bit          seq_on, done_seen, mon_en, start_req;
    bit          prev_wen, prev_stall, prev_cpl;
    logic [31:0] prev_data;
    int          stall_target, stall_len, stall_left, stall_pct, prod_pct;
    bit          stall_used;

    function automatic logic [31:0] bswap(input logic [31:0] w);
        logic [31:0] r;
        r = {<<8{w}};
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic mchk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        if (mon_en) chk(nm, act, exp);
    endtask

    // Word-level model: tracks completed writes and accepted words, not FSM states.
    task automatic monitor();
        bit busy_e, done_e, ir_e;
        int ps, occ;
        if (!rst) begin
            mchk("reset wen", 32'(wen), 0);
            mchk("reset addr", 32'(addr), 0);
            mchk("reset data", data, 0);
            mchk("reset in_ready", 32'(in_ready), 0);
            mchk("reset busy", 32'(busy), 0);
            mchk("reset done", 32'(done), 0);
            mchk("reset sent_cnt", 32'(sent_cnt), 0);
            n_done = 0; n_acc = 0; tail = 0; seq_on = 0; run = 0;
            prev_wen = 0; prev_stall = 0; prev_cpl = 0; prev_data = '0;
            obs.delete(); wlen.delete();
            return;
        end
        if (seq_on) seq_cyc++;
        busy_e = seq_on && !(n_done == N + 2 && tail >= 1);
        done_e = seq_on && n_done == N + 2 && tail >= 1;
        ps = n_done + (wen ? 1 : 0) - 1;
        if (ps < 0) ps = 0;
        if (ps > N) ps = N;
        occ  = n_acc - ps;
        ir_e = busy_e && occ < DEPTH && n_acc < N;
        mchk("busy", 32'(busy), 32'(busy_e));
        mchk("done", 32'(done), 32'(done_e));
        mchk("in_ready", 32'(in_ready), 32'(ir_e));
        mchk("sent_cnt", 32'(sent_cnt), 32'(n_done));
        if (wen) begin
            mchk("addr", 32'(addr), 32'h10);
        end else begin
            mchk("idle addr", 32'(addr), 0);
            mchk("idle data", data, 0);
        end
        if (prev_cpl) mchk("write gap", 32'(wen), 0);
        if (prev_wen && prev_stall) begin
            mchk("hold wen", 32'(wen), 1);
            mchk("hold data", data, prev_data);
        end
        if (done && !done_seen) begin
            done_seen = 1;
            done_at   = seq_cyc;
        end
        if (n_done == N + 2) tail++;
        if (wen) run++;
        if (wen && !stall) begin
            obs.push_back(data);
            wlen.push_back(run);
            run = 0;
            n_done++;
        end
        if (in_valid && in_ready) n_acc++;
        prev_wen = wen; prev_stall = stall; prev_data = data; prev_cpl = wen && !stall;
        if (start && !busy_e) begin
            seq_on = 1; n_done = 0; n_acc = 0; tail = 0; seq_cyc = 0; done_seen = 0;
            obs.delete(); wlen.delete();
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        start     = start_req;
        start_req = 1'b0;
        if (stall_target < 0) stall_used = 1'b0;
        else if (wen && n_done == stall_target && !stall_used) begin
            stall_left = stall_len;
            stall_used = 1'b1;
        end
        stall = (stall_left > 0) || (stall_pct > 0 && int'($urandom_range(99)) < stall_pct);
        if (stall_left > 0) stall_left--;
        if (n_acc < src.size() && int'($urandom_range(99)) < prod_pct) begin
            in_valid = 1'b1;
            in_data  = src[n_acc];
        end else begin
            in_valid = 1'b0;
            in_data  = '0;
        end
        @(negedge clk);
        monitor();
    endtask

    task automatic pulse_start();
        start_req = 1'b1;
        tick();
        tick();
    endtask

    task automatic wait_done(input string nm);
        int k = 0;
        while (!done && k < 3000) begin
            tick();
            k++;
        end
        chk({nm, " done reached"}, 32'(done), 1);
    endtask

    task automatic load_random(input int cnt);
        src.delete();
        for (int i = 0; i < cnt; i++) src.push_back($urandom);
    endtask

    task automatic check_seq(input string nm, input bit use_tbl);
        logic [31:0] e;
        chk({nm, " writes"}, 32'(obs.size()), 32'(N + 2));
        chk({nm, " final sent_cnt"}, 32'(sent_cnt), 32'(N + 2));
        chk({nm, " final done"}, 32'(done), 1);
        if (obs.size() == N + 2) begin
            chk({nm, " begin symbol"}, obs[0], 32'h68010000);
            chk({nm, " end symbol"}, obs[N+1], 32'h5DFDFFFF);
            for (int i = 0; i < N; i++) begin
                e = use_tbl ? tbl[i].dexp : bswap(src[i]);
                chk($sformatf("%s word %0d", nm, i), obs[i+1], e);
            end
        end
    endtask

    initial begin
        tbl[0]  = '{32'h0000DEAD, 32'hADDE0000};
        tbl[1]  = '{32'h6F568000, 32'h0080566F};
        tbl[2]  = '{32'h12345678, 32'h78563412};
        tbl[3]  = '{32'h01020304, 32'h04030201};
        tbl[4]  = '{32'hFFFFFFFF, 32'hFFFFFFFF};
        tbl[5]  = '{32'h00000000, 32'h00000000};
        tbl[6]  = '{32'hA5A5A5A5, 32'hA5A5A5A5};
        tbl[7]  = '{32'h80000001, 32'h01000080};
        tbl[8]  = '{32'hCAFEBABE, 32'hBEBAFECA};
        tbl[9]  = '{32'h00FF00FF, 32'hFF00FF00};
        tbl[10] = '{32'hDEADBEEF, 32'hEFBEADDE};
        tbl[11] = '{32'h11223344, 32'h44332211};
        tbl[12] = '{32'h0F0F0F0F, 32'h0F0F0F0F};
        tbl[13] = '{32'h76543210, 32'h10325476};
        tbl[14] = '{32'h000000FF, 32'hFF000000};
        tbl[15] = '{32'hFF000000, 32'h000000FF};
        tbl[16] = '{32'h13579BDF, 32'hDF9B5713};

        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0; stall = 1'b0;
        start_req = 0; mon_en = 1; stall_target = -1; stall_len = 0; stall_left = 0;
        stall_pct = 0; prod_pct = 100; stall_used = 0;
        #3 rst = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        tick();

        // Table-driven payload, producer at full rate, no stalls
        src.delete();
        for (int i = 0; i < N; i++) src.push_back(tbl[i].din);
        pulse_start();
        chk("start latency wen", 32'(wen), 1);
        wait_done("t1");
        chk("t1 sequence cycles", 32'(done_at), 32'(2 * (N + 2) + 1));
        chk("t1 accepted", 32'(n_acc), 32'(N));
        check_seq("t1", 1);

        // Five-cycle stall on the third write
        stall_target = 2; stall_len = 5;
        pulse_start();
        wait_done("t2");
        if (wlen.size() > 2) begin
            chk("t2 held write data", obs[2], 32'h0080566F);
            chk("t2 held write cycles", 32'(wlen[2]), 6);
        end else chk("t2 third write present", 32'(wlen.size()), 3);
        check_seq("t2", 1);
        stall_target = -1;
        tick();

        // Producer starves after four words; a start while busy must be ignored
        load_random(4);
        pulse_start();
        for (int k = 0; k < 200 && n_done < 5; k++) tick();
        start_req = 1'b1;
        repeat (10) tick();
        chk("t3 starve wen", 32'(wen), 0);
        chk("t3 starve addr", 32'(addr), 0);
        chk("t3 starve busy", 32'(busy), 1);
        chk("t3 starve sent_cnt", 32'(sent_cnt), 5);
        for (int i = 0; i < N - 4; i++) src.push_back($urandom);
        wait_done("t3");
        check_seq("t3", 0);

        // Twenty words offered, only NUM_WORDS may be taken
        load_random(20);
        pulse_start();
        wait_done("t4");
        chk("t4 accepted", 32'(n_acc), 32'(N));
        check_seq("t4", 0);

        // Asynchronous reset while payload word 8 is on the bus
        load_random(N);
        pulse_start();
        for (int k = 0; k < 300 && !(n_done == 8 && wen); k++) tick();
        chk("t5 reached word 8", 32'(wen), 1);
        #2 rst = 1'b0;
        #1;
        chk("t5 async wen", 32'(wen), 0);
        chk("t5 async addr", 32'(addr), 0);
        chk("t5 async data", data, 0);
        chk("t5 async busy", 32'(busy), 0);
        chk("t5 async in_ready", 32'(in_ready), 0);
        chk("t5 async sent_cnt", 32'(sent_cnt), 0);
        repeat (2) tick();
        rst = 1'b1;
        tick();
        pulse_start();
        wait_done("t5");
        check_seq("t5", 0);

        // Randomized stalls and producer gaps
        for (int it = 0; it < 6; it++) begin
            load_random(N + int'($urandom_range(0, 3)));
            stall_pct = int'($urandom_range(0, 40));
            prod_pct  = int'($urandom_range(30, 100));
            pulse_start();
            wait_done($sformatf("rand%0d", it));
            check_seq($sformatf("rand%0d", it), 0);
        end
        stall_pct = 0; prod_pct = 100;

`ifdef TEST_PORT_WRITER_TIMEOUT_EN
        mon_en = 0;
        tick();
        load_random(N);
        stall_target = 2; stall_len = 8;
        pulse_start();
        for (int k = 0; k < 200 && !done; k++) tick();
        chk("t7 timeout wen", 32'(wen), 0);
        chk("t7 timeout flag", 32'(timeout), 1);
        chk("t7 timeout done", 32'(done), 1);
        chk("t7 timeout sent_cnt", 32'(sent_cnt), 2);
        stall_target = -1;
        pulse_start();
        chk("t7 timeout cleared", 32'(timeout), 0);
        chk("t7 restart busy", 32'(busy), 1);
        rst = 1'b0;
        repeat (2) tick();
        mon_en = 1;
        rst = 1'b1;
        tick();
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
